gshare_pht_reader: RTL and testbench

- Prediction-side consumer of the global history register.
- Reads the GHR value each fetch, XORs it with the fetch PC to index a pattern history table (PHT) of 2-bit saturating counters, and returns a taken/not-taken prediction to IF.
- Holds each in-flight prediction's index and predicted bit in a small in-order queue. At EX resolve it updates the right PHT entry, flags mispredicts, and drives the GHR update enable.

---
 rtl/gshare_pht_reader_pkg.sv | 22 ++
 rtl/gshare_pht_reader_if.sv | 33 +++
 rtl/gshare_pht_reader_inflight_fifo.sv | 57 +++++
 rtl/gshare_pht_reader.sv | 82 ++++++++
 tb/tb_gshare_pht_reader.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/gshare_pht_reader_pkg.sv
// Shared branch-predictor types: 2-bit saturating counter, its named states,
// and the saturating update used by the PHT.
package gshare_pht_reader_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'd0;   // strongly not-taken
    localparam ctr_t WNT = 2'd1;   // weakly not-taken
    localparam ctr_t WT  = 2'd2;   // weakly taken
    localparam ctr_t ST  = 2'd3;   // strongly taken

    localparam ctr_t PHT_RST = WNT;

    function automatic ctr_t sat_update(ctr_t c, logic taken);
        if (taken) begin
            return (c == ST) ? ST : ctr_t'(c + 2'd1);
        end else begin
            return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
        end
    endfunction

endpackage

// File: rtl/gshare_pht_reader_if.sv
// Lookup/resolve bundle between the IF/EX pipeline (master) and the predictor (slave).
interface gshare_pht_reader_if #(
    parameter int HISTORY_WIDTH  = 8,
    parameter int PC_WIDTH       = 32,
    parameter int INFLIGHT_DEPTH = 4
);
    logic                              lookup_valid_i;
    logic [PC_WIDTH-1:0]               lookup_pc_i;
    logic [HISTORY_WIDTH-1:0]          ghr_data_i;
    logic                              lookup_ready_o;
    logic                              pred_taken_o;
    logic                              resolve_valid_i;
    logic                              resolve_taken_i;
    logic                              flush_i;
    logic                              mispredict_o;
    logic                              ghr_update_en_o;
    logic [$clog2(INFLIGHT_DEPTH):0]   inflight_cnt_o;
    logic                              resolve_err_o;

    modport master (
        output lookup_valid_i, lookup_pc_i, ghr_data_i,
               resolve_valid_i, resolve_taken_i, flush_i,
        input  lookup_ready_o, pred_taken_o, mispredict_o,
               ghr_update_en_o, inflight_cnt_o, resolve_err_o
    );

    modport slave (
        input  lookup_valid_i, lookup_pc_i, ghr_data_i,
               resolve_valid_i, resolve_taken_i, flush_i,
        output lookup_ready_o, pred_taken_o, mispredict_o,
               ghr_update_en_o, inflight_cnt_o, resolve_err_o
    );
endinterface

// File: rtl/gshare_pht_reader_inflight_fifo.sv
// Generic synchronous FIFO with flush; head data is visible combinationally.
module bp_inflight_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_head];
    // A push at full is only legal when the head leaves in the same cycle.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && !i_flush && (!o_full || w_pop_ok);

    // Storage write; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_tail] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2**AW).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_tail <= r_tail + 1'b1;
            if (w_pop_ok)  r_head <= r_head + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop_ok};
        end
    end
endmodule

// File: rtl/gshare_pht_reader.sv
// Gshare prediction side: PC^GHR indexes a table of 2-bit counters; in-flight
// predictions are queued in order and retrained when EX resolves them.
module gshare_pht_reader
    import gshare_pht_reader_pkg::*;
#(
    parameter int HISTORY_WIDTH  = 8,
    parameter int PC_WIDTH       = 32,
    parameter int INFLIGHT_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    gshare_pht_reader_if.slave    bus
);
    localparam int PHT_SIZE = 2 ** HISTORY_WIDTH;

    typedef struct packed {
        logic [HISTORY_WIDTH-1:0] idx;
        logic                     pred;
    } entry_t;

    ctr_t                     r_pht [PHT_SIZE];
    logic                     r_resolve_err;
    logic [HISTORY_WIDTH-1:0] w_idx;
    logic                     w_pred;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_empty;
    entry_t                   w_wdata;
    entry_t                   w_head;
    logic                     w_unused_pc;

    assign w_idx       = bus.lookup_pc_i[HISTORY_WIDTH+1:2] ^ bus.ghr_data_i;
    assign w_unused_pc = ^{bus.lookup_pc_i[PC_WIDTH-1:HISTORY_WIDTH+2], bus.lookup_pc_i[1:0]};
    // No bypass: a lookup colliding with this cycle's retrain sees the old counter.
    assign w_pred      = r_pht[w_idx][1];
    assign w_pop       = bus.resolve_valid_i && !w_empty;
    assign w_push      = bus.lookup_valid_i && bus.lookup_ready_o && !bus.flush_i;
    assign w_wdata     = '{idx: w_idx, pred: w_pred};

    assign bus.pred_taken_o    = w_pred;
    assign bus.lookup_ready_o  = !w_full || w_pop;
    assign bus.mispredict_o    = w_pop && (w_head.pred ^ bus.resolve_taken_i);
    assign bus.ghr_update_en_o = w_pop;
    assign bus.resolve_err_o   = r_resolve_err;

    bp_inflight_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (INFLIGHT_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.flush_i),
        .i_data  (w_wdata),
        .o_data  (w_head),
        .o_count (bus.inflight_cnt_o),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Retrain the resolved entry's counter; whole table returns to weakly not-taken on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PHT_SIZE; i++) begin
                r_pht[i] <= PHT_RST;
            end
        end else if (w_pop) begin
            r_pht[w_head.idx] <= sat_update(r_pht[w_head.idx], bus.resolve_taken_i);
        end
    end

    // Sticky flag for a resolve that had no in-flight prediction to match.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_resolve_err <= 1'b0;
        end else if (bus.resolve_valid_i && w_empty) begin
            r_resolve_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_gshare_pht_reader.sv
// Scoreboard bench: driver computes expectations from a queue/array model,
// monitor compares them against the DUT on the falling edge.
module tb_gshare_pht_reader;
    localparam int HW    = 8;
    localparam int PW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        int idx;
        bit pred;
    } ent_t;

    typedef struct {
        bit lv;
        bit pred;
        bit ready;
        bit misp;
        bit ghr_en;
        int cnt;
        bit err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int   n_cmp = 0;
    int   n_err = 0;

    int   pht_m [2**HW];
    ent_t q_m [$];
    bit   err_m;
    exp_t exp_q [$];

    gshare_pht_reader_if #(.HISTORY_WIDTH(HW), .PC_WIDTH(PW), .INFLIGHT_DEPTH(DEPTH)) bus ();

    gshare_pht_reader #(.HISTORY_WIDTH(HW), .PC_WIDTH(PW), .INFLIGHT_DEPTH(DEPTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        foreach (pht_m[i]) pht_m[i] = 1;
        q_m.delete();
        err_m = 1'b0;
    endfunction

    function automatic int idx_of(logic [PW-1:0] pc, logic [HW-1:0] ghr);
        logic [PW-1:0] word;
        word = pc >> 2;
        return int'(word[HW-1:0] ^ ghr);
    endfunction

    task automatic drive(bit lv, logic [PW-1:0] pc, logic [HW-1:0] ghr, bit rv, bit rt, bit fl);
        bus.lookup_valid_i  = lv;
        bus.lookup_pc_i     = pc;
        bus.ghr_data_i      = ghr;
        bus.resolve_valid_i = rv;
        bus.resolve_taken_i = rt;
        bus.flush_i         = fl;
    endtask

    // One clock of stimulus; expectation is pushed before the model advances.
    task automatic cyc(bit lv, logic [PW-1:0] pc, logic [HW-1:0] ghr, bit rv, bit rt, bit fl);
        exp_t e;
        ent_t h;
        int   idx;
        bit   pop, ready, push;
        @(posedge clk);
        #1;
        drive(lv, pc, ghr, rv, rt, fl);
        idx   = idx_of(pc, ghr);
        pop   = rv && (q_m.size() > 0);
        ready = (q_m.size() < DEPTH) || pop;
        push  = lv && ready && !fl;
        e.lv     = lv;
        e.pred   = (pht_m[idx] >= 2);
        e.ready  = ready;
        e.misp   = pop && (q_m[0].pred != rt);
        e.ghr_en = pop;
        e.cnt    = q_m.size();
        e.err    = err_m;
        exp_q.push_back(e);
        if (pop) begin
            h = q_m.pop_front();
            if (rt) pht_m[h.idx] = (pht_m[h.idx] == 3) ? 3 : pht_m[h.idx] + 1;
            else    pht_m[h.idx] = (pht_m[h.idx] == 0) ? 0 : pht_m[h.idx] - 1;
        end
        if (fl)        q_m.delete();
        else if (push) q_m.push_back('{idx: idx, pred: e.pred});
        if (rv && !pop) err_m = 1'b1;
    endtask

    // Asynchronous reset pulse, checked while rst_n is still low.
    task automatic reset_pulse();
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(1'b1, 32'h0000_0100, 8'h00, 1'b0, 1'b0, 1'b0);
        model_reset();
        e = '{lv: 1'b1, pred: (pht_m[idx_of(32'h100, 8'h00)] >= 2), ready: 1'b1,
              misp: 1'b0, ghr_en: 1'b0, cnt: 0, err: 1'b0};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, '0, '0, (q_m.size() > 0), 1'b1, 1'b0);
    endtask

    // Monitor: whenever an expectation is due, compare every DUT output.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.lv) chk("pred_taken", int'(bus.pred_taken_o), int'(e.pred));
                chk("lookup_ready",  int'(bus.lookup_ready_o),  int'(e.ready));
                chk("mispredict",    int'(bus.mispredict_o),    int'(e.misp));
                chk("ghr_update_en", int'(bus.ghr_update_en_o), int'(e.ghr_en));
                chk("inflight_cnt",  int'(bus.inflight_cnt_o),  e.cnt);
                chk("resolve_err",   int'(bus.resolve_err_o),   int'(e.err));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [PW-1:0] pc;
        logic [HW-1:0] ghr;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        model_reset();
        reset_pulse();

        // First lookup at index 0x04, then train it taken.
        cyc(1, 32'h0000_0010, 8'h00, 0, 0, 0);
        cyc(0, '0, '0, 1, 1, 0);
        cyc(1, 32'h0000_0010, 8'h00, 0, 0, 0);
        cyc(0, '0, '0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h0000_0010, 8'h00, 0, 0, 0);
            cyc(0, '0, '0, 1, 1, 0);
        end
        // Saturated at 3: one not-taken keeps it taken, the second drops below.
        for (int i = 0; i < 2; i++) begin
            cyc(1, 32'h0000_0010, 8'h00, 0, 0, 0);
            cyc(0, '0, '0, 1, 0, 0);
        end
        cyc(1, 32'h0000_0010, 8'h00, 0, 0, 0);
        drain();

        // Fill, overfill attempt, then push+pop at full across pointer wrap.
        for (int i = 0; i < DEPTH; i++) cyc(1, 32'h0000_0020 + 32'(i * 4), 8'h00, 0, 0, 0);
        cyc(1, 32'h0000_0080, 8'h00, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 32'h0000_0040 + 32'(i * 4), 8'h0F, 1, i[0], 0);
        drain();

        // Flush with same-cycle pop and dropped push.
        cyc(1, 32'h0000_0030, 8'h00, 0, 0, 0);
        cyc(1, 32'h0000_0034, 8'h00, 0, 0, 0);
        cyc(1, 32'h0000_0038, 8'h00, 1, 0, 1);
        cyc(0, '0, '0, 0, 0, 0);
        cyc(1, 32'h0000_0030, 8'h00, 0, 0, 0);
        drain();

        // Resolve on an empty queue, sticky error.
        cyc(0, '0, '0, 1, 1, 0);
        cyc(0, '0, '0, 0, 0, 0);
        cyc(0, '0, '0, 0, 0, 0);

        // Same-index lookup and taken resolve in one cycle (counter at 1).
        cyc(1, 32'h0000_0100, 8'h00, 0, 0, 0);
        cyc(1, 32'h0000_0100, 8'h00, 1, 1, 0);
        cyc(1, 32'h0000_0100, 8'h00, 0, 0, 0);
        reset_pulse();
        cyc(1, 32'h0000_0100, 8'h00, 0, 0, 0);
        cyc(0, '0, '0, 0, 0, 0);
        drain();

        // Randomized traffic with frequent index collisions.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                pc  = 32'h0000_1000 + 32'($urandom_range(0, 7) << 2);
                ghr = HW'($urandom_range(0, 3));
            end else begin
                pc  = $urandom;
                ghr = HW'($urandom);
            end
            cyc(($urandom_range(0, 9) < 7), pc, ghr, ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 1) == 1), ($urandom_range(0, 39) == 0));
            if ($urandom_range(0, 499) == 0) reset_pulse();
        end

        cyc(0, '0, '0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
